// File: rtl/stream_segmenter_pkg.sv
// Shared types and constants for the stream segmenter (default 128-to-32 configuration).
// The top recomputes its own widths from its parameters; these describe the default build.
package stream_segmenter_pkg;

  localparam int DEF_DATA_IN_W  = 128;
  localparam int DEF_DATA_OUT_W = 32;
  localparam int DEF_SEG_BEATS  = 16;
  localparam int DEF_DEPTH      = 4;

  localparam int R     = DEF_DATA_IN_W / DEF_DATA_OUT_W;
  localparam int IDX_W = $clog2(R);
  localparam int SEG_W = $clog2(DEF_SEG_BEATS + 1);
  localparam int PTR_W = $clog2(DEF_DEPTH) + 1;

  typedef struct packed {
    logic [DEF_DATA_IN_W-1:0] tdata;
    logic [R-1:0]             tkeep;
    logic                     tlast;
  } entry_t;

endpackage

// File: rtl/seg_fifo.sv
// Input FIFO with a registered array and a combinational head (read-first).
// Pointers carry one extra wrap bit to tell full from empty.
module seg_fifo
  import stream_segmenter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/stream_segmenter.sv
// Wide-to-narrow AXI-Stream serialiser that cuts the word stream into bounded segments.
// A frame end always closes the current segment; long frames are split every SEG_BEATS words.
module stream_segmenter
  import stream_segmenter_pkg::*;
#(
  parameter int DATA_IN_W  = DEF_DATA_IN_W,
  parameter int DATA_OUT_W = DEF_DATA_OUT_W,
  parameter int SEG_BEATS  = DEF_SEG_BEATS,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_W-1:0]              s_axis_tdata,
  input  logic [DATA_IN_W/DATA_OUT_W-1:0]   s_axis_tkeep,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [DATA_OUT_W-1:0]             m_axis_tdata,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              err_keep
);

  localparam int WORDS    = DATA_IN_W / DATA_OUT_W;
  localparam int IDX_BITS = $clog2(WORDS);
  localparam int CNT_BITS = $clog2(SEG_BEATS + 1);
  localparam int ENTRY_W  = DATA_IN_W + WORDS + 1;

  logic                  ready_en;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  s_fire;
  logic                  m_fire;
  logic                  last_word;
  logic [ENTRY_W-1:0]    head;
  logic [DATA_IN_W-1:0]  head_data;
  logic [WORDS-1:0]      head_keep;
  logic                  head_last;
  logic [IDX_BITS-1:0]   word_idx;
  logic [IDX_BITS-1:0]   last_idx;
  logic [CNT_BITS-1:0]   seg_cnt;
  logic [DATA_OUT_W-1:0] words [WORDS];

  // Index of the last word in the leading run of ones; bits past the first zero are ignored.
  function automatic logic [IDX_BITS-1:0] keep_last(input logic [WORDS-1:0] keep);
    logic run;
    keep_last = '0;
    run       = keep[0];
    for (int i = 1; i < WORDS; i++) begin
      run = run & keep[i];
      if (run) keep_last = IDX_BITS'(i);
    end
  endfunction

  // ready_en keeps the input closed during reset and opens it on the first edge after release.
  assign s_axis_tready = ready_en & ~full;
  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign push          = s_fire & s_axis_tkeep[0];

  seg_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_data = head[ENTRY_W-1 -: DATA_IN_W];
  assign head_keep = head[WORDS:1];
  assign head_last = head[0];

  generate
    for (genvar g = 0; g < WORDS; g++) begin : g_word
      assign words[g] = head_data[DATA_IN_W-1-g*DATA_OUT_W -: DATA_OUT_W];
    end
  endgenerate

  always_comb last_idx = keep_last(head_keep);

  assign m_axis_tdata  = words[word_idx];
  assign m_axis_tvalid = ~empty;
  assign m_fire        = m_axis_tvalid & m_axis_tready;
  assign last_word     = (word_idx == last_idx);
  assign pop           = m_fire & last_word;
  assign m_axis_tuser  = (seg_cnt == '0);
  assign m_axis_tlast  = (seg_cnt == CNT_BITS'(SEG_BEATS - 1)) | (last_word & head_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      err_keep <= 1'b0;
      word_idx <= '0;
      seg_cnt  <= '0;
    end else begin
      ready_en <= 1'b1;
      err_keep <= s_fire & ~s_axis_tkeep[0];
      if (m_fire) begin
        word_idx <= last_word ? '0 : word_idx + IDX_BITS'(1);
        seg_cnt  <= m_axis_tlast ? '0 : seg_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_segmenter.sv
// Scoreboard bench for stream_segmenter: driver pushes expected words, monitor pops and compares.
module tb_stream_segmenter;

  localparam int SEG = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] s_tdata = '0;
  logic [3:0]   s_tkeep = '0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [31:0]  m_tdata;
  logic         m_tuser;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         err_keep;

  int tests = 0;
  int fails = 0;
  int m_seg = 0;
  int words_seen = 0;
  int sop_seen = 0;
  int eop_seen = 0;
  int cur_len = 0;
  logic [33:0] q [$];
  bit done;

  stream_segmenter #(
    .DATA_IN_W  (128),
    .DATA_OUT_W (32),
    .SEG_BEATS  (SEG),
    .DEPTH      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .err_keep      (err_keep)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expand an accepted beat into expected words with segment markers.
  task automatic model_push(input logic [127:0] d, input logic [3:0] k, input logic l);
    int n;
    logic tu, tl;
    n = 0;
    while (n < 4 && k[n]) n++;
    for (int w = 0; w < n; w++) begin
      tu = (m_seg == 0);
      tl = (m_seg == SEG - 1) || ((w == n - 1) && l);
      q.push_back({d[127-32*w -: 32], tu, tl});
      m_seg = tl ? 0 : m_seg + 1;
    end
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check("send_timeout", 64'(n), 64'(0));
    else model_push(d, k, l);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || m_tvalid) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain_timeout"}, 64'(n < 2000), 64'(1));
  endtask

  task automatic clear_counts();
    words_seen = 0; sop_seen = 0; eop_seen = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", m_tdata);
      end else begin
        check("word", {30'd0, m_tdata, m_tuser, m_tlast}, {30'd0, q.pop_front()});
      end
      words_seen++;
      if (m_tuser) begin sop_seen++; cur_len = 1; end
      else cur_len++;
      if (m_tlast) begin
        eop_seen++;
        check("seg_len_le6", 64'(cur_len <= SEG), 64'(1));
      end
    end
  end

  initial begin
    int idle, r, nk;
    logic [3:0] k;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_err_keep", err_keep, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("tready_after_rst", s_tready, 1);

    // single beat, one frame
    clear_counts();
    m_tready = 1'b1;
    send_beat(128'h00010002_00030004_00050006_00070008, 4'b1111, 1'b1);
    check("latency_valid", m_tvalid, 1);
    check("latency_word0", m_tdata, 32'h00010002);
    check("latency_tuser", m_tuser, 1);
    drain("single");
    check("single_words", 64'(words_seen), 4);
    check("single_eop", 64'(eop_seen), 1);

    // 10-word frame split 6 + 4
    clear_counts();
    send_beat(128'h11111111_11111112_11111113_11111114, 4'b1111, 1'b0);
    send_beat(128'h22222221_22222222_22222223_22222224, 4'b1111, 1'b0);
    send_beat(128'h33333331_33333332_33333333_33333334, 4'b0011, 1'b1);
    drain("split");
    check("split_words", 64'(words_seen), 10);
    check("split_sop", 64'(sop_seen), 2);
    check("split_eop", 64'(eop_seen), 2);

    // backpressure: FIFO fills after 4 beats, output holds
    clear_counts();
    m_tready = 1'b0;
    send_beat(128'h10000001_10000002_10000003_10000004, 4'b1111, 1'b0);
    send_beat(128'h20000001_20000002_20000003_20000004, 4'b1111, 1'b0);
    send_beat(128'h30000001_30000002_30000003_30000004, 4'b1111, 1'b0);
    send_beat(128'h40000001_40000002_40000003_40000004, 4'b1111, 1'b0);
    check("full_tready", s_tready, 0);
    fork
      send_beat(128'h50000001_50000002_50000003_50000004, 4'b1111, 1'b1);
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("stall_tdata", m_tdata, 32'h10000001);
          check("stall_tvalid", m_tvalid, 1);
          check("stall_tready", s_tready, 0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain("stall");
    check("stall_words", 64'(words_seen), 20);
    check("stall_eop", 64'(eop_seen), 4);

    // bad keep: discarded with a one-cycle err_keep
    clear_counts();
    send_beat(128'hdeadbeef_deadbeef_deadbeef_deadbeef, 4'b1110, 1'b1);
    check("errkeep_pulse", err_keep, 1);
    check("errkeep_no_valid", m_tvalid, 0);
    @(posedge clk);
    #1;
    check("errkeep_clear", err_keep, 0);
    repeat (3) @(posedge clk);
    #1;
    check("errkeep_words", 64'(words_seen), 0);

    // async reset with two words pending
    clear_counts();
    m_tready = 1'b0;
    send_beat(128'h55550001_55550002_55550003_55550004, 4'b1111, 1'b0);
    m_tready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    m_tready = 1'b0;
    check("pre_rst_words", 64'(words_seen), 2);
    check("pre_rst_valid", m_tvalid, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", m_tvalid, 0);
    check("async_rst_tready", s_tready, 0);
    q.delete();
    m_seg = 0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    clear_counts();
    m_tready = 1'b1;
    send_beat(128'h66660001_66660002_66660003_66660004, 4'b1111, 1'b1);
    check("post_rst_tuser", m_tuser, 1);
    drain("post_rst");
    check("post_rst_sop", 64'(sop_seen), 1);
    check("post_rst_words", 64'(words_seen), 4);

    // random valid/ready traffic
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          idle = $urandom_range(0, 2);
          repeat (idle) begin @(posedge clk); #1; end
          r = $urandom_range(0, 9);
          if (r == 0) k = {3'($urandom), 1'b0};
          else if (r == 1) k = 4'b1011;
          else begin
            nk = $urandom_range(1, 4);
            k = 4'((1 << nk) - 1);
          end
          send_beat({$urandom, $urandom, $urandom, $urandom}, k, ($urandom_range(0, 2) == 0));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_tready = 1'b1;
    drain("random");
    check("random_queue_empty", 64'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
